// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int         MC_CNT_W = 4;
    localparam logic [4:0] REG_X0   = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirect
// flushes and a counted freeze of the front end while a multi-cycle op holds EX.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mc_op,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Entry cycle is one stall; the counter covers the remaining MC_LAT-2 stalls.
    localparam logic [MC_CNT_W-1:0] MC_RELOAD = (MC_LAT > 1) ? MC_CNT_W'(MC_LAT - 2) : '0;
    localparam logic [MC_CNT_W-1:0] CNT_ONE   = {{(MC_CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    state_e              state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q;
    logic [MC_CNT_W-1:0] mc_cnt_d;
    logic                load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mc_op) begin
                    if (MC_LAT > 1) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_flush = 1'b1;
                        state_d     = MC_WAIT;
                        mc_cnt_d    = MC_RELOAD;
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            MC_WAIT: begin
                if (mc_cnt_q != '0) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_flush = 1'b1;
                    mc_cnt_d    = mc_cnt_q - CNT_ONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_stall  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign mc_busy = (state_q == MC_WAIT);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (pc_stall),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controller builds (MC_LAT=4/CNT_W=8 and MC_LAT=1/CNT_W=4)
// share one randomized input stream and are checked against an occupancy model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] idRs1 = '0;
    logic [4:0] idRs2 = '0;
    logic       idUsesRs1 = 1'b0;
    logic       idUsesRs2 = 1'b0;
    logic [4:0] exRd = '0;
    logic       exMemRead = 1'b0;
    logic       exMcOp = 1'b0;
    logic       exRedirect = 1'b0;

    logic       pcStallA, ifidStallA, ifidFlushA, idexStallA, idexFlushA, exmemFlushA, mcBusyA;
    logic [7:0] stallCyclesA;
    logic       pcStallB, ifidStallB, ifidFlushB, idexStallB, idexFlushB, exmemFlushB, mcBusyB;
    logic [3:0] stallCyclesB;

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
        .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_mc_op(exMcOp), .ex_redirect(exRedirect),
        .pc_stall(pcStallA), .ifid_stall(ifidStallA), .ifid_flush(ifidFlushA),
        .idex_stall(idexStallA), .idex_flush(idexFlushA), .exmem_flush(exmemFlushA),
        .mc_busy(mcBusyA), .stall_cycles(stallCyclesA)
    );

    pipe_hazard_ctrl #(.MC_LAT(1), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst),
        .id_rs1(idRs1), .id_rs2(idRs2), .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
        .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_mc_op(exMcOp), .ex_redirect(exRedirect),
        .pc_stall(pcStallB), .ifid_stall(ifidStallB), .ifid_flush(ifidFlushB),
        .idex_stall(idexStallB), .idex_flush(idexFlushB), .exmem_flush(exmemFlushB),
        .mc_busy(mcBusyB), .stall_cycles(stallCyclesB)
    );

    // Flag vectors are {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}.
    typedef struct {
        logic       isReset;
        logic [5:0] flagsA;
        logic [5:0] flagsB;
        logic       busyA;
        logic       busyB;
        int         cntA;
        int         cntB;
    } expect_t;

    expect_t expQ[$];
    int total = 0;
    int bad   = 0;

    // Reference state: index of the current EX cycle of an in-flight op (0 = none).
    int nextKA = 0;
    int cntA   = 0;
    int nextKB = 0;
    int cntB   = 0;

    task automatic modelStep(input int lat, input int maxCnt, input logic loadUse,
                             inout int nextK, inout int cnt,
                             output logic [5:0] flags, output logic busy, output int seenCnt);
        int k;
        flags   = 6'b000000;
        busy    = 1'b0;
        seenCnt = cnt;
        if (rst) begin
            nextK = 0;
            cnt   = 0;
        end else begin
            k = nextK;
            if (k == 0) begin
                if (exRedirect) begin
                    flags = 6'b001010;
                end else if (exMcOp) begin
                    if (lat > 1) begin
                        k     = 1;
                        flags = 6'b110101;
                    end
                end else if (loadUse) begin
                    flags = 6'b110010;
                end
            end else begin
                busy = 1'b1;
                if (k < lat) flags = 6'b110101;
            end
            if (flags[5] && cnt < maxCnt) cnt = cnt + 1;
            nextK = (k > 0 && k < lat) ? k + 1 : 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic redir, input logic mc, input logic mr,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2);
        expect_t e;
        logic    lu;
        @(posedge clk);
        #1;
        rst        = r;
        exRedirect = redir;
        exMcOp     = mc;
        exMemRead  = mr;
        exRd       = rd;
        idRs1      = rs1;
        idRs2      = rs2;
        idUsesRs1  = u1;
        idUsesRs2  = u2;
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.isReset = r;
        modelStep(4, 255, lu, nextKA, cntA, e.flagsA, e.busyA, e.cntA);
        modelStep(1, 15, lu, nextKB, cntB, e.flagsB, e.busyB, e.cntB);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
        end
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("flagsA", int'({pcStallA, ifidStallA, ifidFlushA, idexStallA, idexFlushA, exmemFlushA}), int'(e.flagsA));
            checkOutput("flagsB", int'({pcStallB, ifidStallB, ifidFlushB, idexStallB, idexFlushB, exmemFlushB}), int'(e.flagsB));
            checkOutput("stallCyclesA", int'(stallCyclesA), e.cntA);
            checkOutput("stallCyclesB", int'(stallCyclesB), e.cntB);
            if (!e.isReset) begin
                checkOutput("mcBusyA", int'(mcBusyA), int'(e.busyA));
                checkOutput("mcBusyB", int'(mcBusyB), int'(e.busyB));
            end
        end
    end

    initial begin
        logic r, redir, mc, mr;
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Basic load-use, x0 destination, shared rs1/rs2, redirect override.
        applyStimulus(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        applyStimulus(0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 1);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 1, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1);
        applyStimulus(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Two back-to-back multi-cycle ops, then an idle cycle.
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Reset during the second MC_WAIT cycle, then a normal load-use.
        applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Saturation: 20 load-use stalls fill the 4-bit counter, long MC stream fills the 8-bit one.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 5'd9, 5'd9, 5'd2, 1, 1);
        for (int i = 0; i < 400; i++) applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 5'd9, 5'd9, 5'd2, 1, 1);

        for (int i = 0; i < 1500; i++) begin
            r     = ($urandom_range(0, 49) == 0);
            redir = ($urandom_range(0, 5) == 0);
            mc    = ($urandom_range(0, 9) == 0);
            mr    = !mc && ($urandom_range(0, 1) == 1);
            applyStimulus(r, redir, mc, mr,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline; sequences the IF/ID, ID/EX and EX/MEM pipeline registers. Detects load-use hazards between ID and EX, converts taken branches/jumps resolved in EX into front-end flushes, and runs a counter FSM that freezes the front end while a multi-cycle operation (mul/div) occupies EX. Also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MC_LAT, 4: total EX occupancy in cycles of a multi-cycle op; legal range 1..16.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high, one clock.
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  instruction in ID actually reads rs1/rs2.
- ex_rd  in  5  destination index of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_mc_op  in  1  instruction in EX is multi-cycle.
- ex_redirect  in  1  branch/jump in EX is taken; PC is being redirected.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID.
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  zero ID/EX (drives the ID/EX register flush input).
- exmem_flush  out  1  insert a bubble into EX/MEM.
- mc_busy  out  1  FSM in MC_WAIT.
- stall_cycles  out  CNT_W  cycles with pc_stall high, saturating.

## Operation
- States: RUN, MC_WAIT. Registered counter mc_cnt, width 4.
- RUN, priority ex_redirect > ex_mc_op > load-use:
  - ex_redirect: ifid_flush=1, idex_flush=1, no stalls. ex_mc_op in the same cycle is ignored.
  - ex_mc_op with MC_LAT>1: pc_stall, ifid_stall, idex_stall, exmem_flush all 1. Next state MC_WAIT, mc_cnt<=MC_LAT-2.
  - ex_mc_op with MC_LAT==1: no action; stay in RUN.
  - Load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)) gives pc_stall=1, ifid_stall=1, idex_flush=1. Exactly one bubble.
- MC_WAIT:
  - mc_cnt!=0: same four stall/bubble outputs as the entry cycle; mc_cnt decrements.
  - mc_cnt==0: release cycle. All stall/flush outputs 0; next state RUN.
  - ex_mc_op, ex_redirect and load-use are ignored throughout MC_WAIT.
- stall_cycles increments on every cycle with pc_stall=1 and holds at all-ones.
- Stall/flush outputs are combinational from state, mc_cnt and current inputs.

## Timing
- rst (sampled at clk edge): state<=RUN, mc_cnt<=0, stall_cycles<=0. All combinational outputs are forced to 0 while rst is high.
- Reset during MC_WAIT abandons the op; the first cycle after reset is RUN with no stall.
- Latency:
  - Load-use, redirect and MC-entry responses take effect in the same cycle as the triggering inputs.
  - MC op: pc_stall is high for exactly MC_LAT-1 consecutive cycles, then one release cycle. EX occupancy is MC_LAT cycles.
- Back-to-back MC ops: the second op enters EX the cycle after release and starts a new sequence in RUN with no gap.
- Load-use with ex_rd==0 gives no stall. Same register on both rs1 and rs2 gives a single bubble.
- mc_busy is a registered decode of state; it is 0 in the entry cycle and 1 through the release cycle.

## Structure
- Package pipe_ctrl_pkg holds the state enum (RUN, MC_WAIT), REG_X0 = 5'd0, and MC_CNT_W = 4.
- One natural sub-module: sat_counter (parameter W, inputs clk/rst/inc, output count) for stall_cycles. Everything else is inline.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_stall=ifid_stall=idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Redirect plus load-use in the same cycle → ifid_flush=idex_flush=1, pc_stall=0.
- MC op, MC_LAT=4: ex_mc_op=1 held → pc_stall high for 3 cycles, then release cycle with all outputs 0, then RUN. mc_busy high for cycles 2–4. stall_cycles=3.
- MC_LAT=1 build: ex_mc_op=1 → no stall, state stays RUN.
- rst asserted in the 2nd MC_WAIT cycle → next cycle: RUN, all outputs 0, stall_cycles=0. A load-use presented afterwards stalls normally.
- Saturation: CNT_W=4, force 20 stall cycles → stall_cycles=15 and holds.
